// File: rtl/matrix_exec_engine.sv
// Multi-cycle fetch/decode/execute engine feeding the matrix ALU from data memory.
// Optional ALU watchdog in EXEC is enabled by defining EXEC_WATCHDOG_EN.
module matrix_exec_engine #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 8,
  parameter int IADDR_W     = 7,
  parameter int NUM_CELLS   = 8,
  parameter int REG_CODE    = 7,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [31:0]        inst_data,
  input  logic               inst_valid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               reg_we,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic [7:0]         alu_op,
  output logic [7:0]         alu_operand2,
  output logic [DATA_W-1:0]  alu_mat_in,
  output logic               alu_load1,
  output logic               alu_load2,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_done,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_SCALE = 8'h03;
  localparam logic [7:0] OP_TRANS = 8'h04;
  localparam logic [7:0] OP_MULT  = 8'h05;
  localparam logic [7:0] OP_STOP  = 8'hFF;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_SRC1, S_SRC2, S_LOAD2, S_EXEC, S_WRITE, S_HALT, S_ERROR
  } state_t;

  state_t              state_q;
  logic [IADDR_W-1:0]  pc_q;
  logic [31:0]         instr_q;
  logic                mem_en_q, mem_we_q, reg_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, reg_wdata_q;
  logic [7:0]          alu_op_q, alu_operand2_q;
  logic                alu_load1_q, alu_load2_q;
  logic                busy_q, halted_q, error_q;
  logic [1:0]          err_code_q;

  logic [7:0] op, dst, src1, src2;
  logic       is_bin, is_un, op_legal, addr_fault;

  function automatic logic in_range(input logic [7:0] a);
    return {24'd0, a} < 32'(NUM_CELLS);
  endfunction

  assign op   = instr_q[31:24];
  assign dst  = instr_q[23:16];
  assign src1 = instr_q[15:8];
  assign src2 = instr_q[7:0];

  assign is_bin     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT);
  assign is_un      = (op == OP_SCALE) || (op == OP_TRANS);
  assign op_legal   = is_bin || is_un || (op == OP_NOP) || (op == OP_STOP);
  // src2 is a scalar for SCALE and unused for TRANS, so only binary ops range-check it
  assign addr_fault = !in_range(dst) || !in_range(src1) || (is_bin && !in_range(src2));

`ifdef EXEC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_FETCH;
      pc_q           <= '0;
      instr_q        <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      reg_we_q       <= 1'b0;
      reg_wdata_q    <= '0;
      alu_op_q       <= '0;
      alu_operand2_q <= '0;
      alu_load1_q    <= 1'b0;
      alu_load2_q    <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= 2'b00;
`ifdef EXEC_WATCHDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      busy_q      <= 1'b1;
      alu_load1_q <= 1'b0;
      alu_load2_q <= 1'b0;
      mem_we_q    <= 1'b0;
      reg_we_q    <= 1'b0;
`ifdef EXEC_WATCHDOG_EN
      if (state_q != S_EXEC) wdog_q <= '0;
`endif
      case (state_q)
        S_FETCH: begin
          if (inst_valid) begin
            instr_q        <= inst_data;
            alu_op_q       <= inst_data[31:24];
            alu_operand2_q <= inst_data[7:0];
            state_q        <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == OP_NOP) begin
            pc_q    <= pc_q + IADDR_W'(1);
            state_q <= S_FETCH;
          end else if (op == OP_STOP) begin
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_HALT;
          end else if (!op_legal || addr_fault) begin
            error_q    <= 1'b1;
            err_code_q <= !op_legal ? 2'b01 : 2'b11;
            busy_q     <= 1'b0;
            state_q    <= S_ERROR;
          end else begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(src1);
            state_q    <= S_SRC1;
          end
        end
        S_SRC1: begin
          alu_load1_q <= 1'b1;
          state_q     <= S_SRC2;
          if (is_bin) mem_addr_q <= ADDR_W'(src2);
          else        mem_en_q   <= 1'b0;
        end
        S_SRC2: begin
          mem_en_q <= 1'b0;
          if (is_bin) begin
            alu_load2_q <= 1'b1;
            state_q     <= S_LOAD2;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_LOAD2: state_q <= S_EXEC;
        S_EXEC: begin
          if (alu_done) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ADDR_W'(dst);
            mem_wdata_q <= alu_result;
            if (dst == 8'(REG_CODE)) begin
              reg_we_q    <= 1'b1;
              reg_wdata_q <= alu_result;
            end
            state_q <= S_WRITE;
          end
`ifdef EXEC_WATCHDOG_EN
          else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
            error_q    <= 1'b1;
            err_code_q <= 2'b10;
            busy_q     <= 1'b0;
            state_q    <= S_ERROR;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
`endif
        end
        S_WRITE: begin
          mem_en_q <= 1'b0;
          pc_q     <= pc_q + IADDR_W'(1);
          state_q  <= S_FETCH;
        end
        S_HALT, S_ERROR: busy_q <= 1'b0;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Read data reaches the ALU in the same cycle as its load strobe; a reset
  // arriving during WRITE suppresses that cycle's write strobes.
  assign alu_mat_in   = (alu_load1_q || alu_load2_q) ? mem_rdata : '0;
  assign mem_we       = mem_we_q & ~reset;
  assign reg_we       = reg_we_q & ~reset;
  assign inst_addr    = pc_q;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign reg_wdata    = reg_wdata_q;
  assign alu_op       = alu_op_q;
  assign alu_operand2 = alu_operand2_q;
  assign alu_load1    = alu_load1_q;
  assign alu_load2    = alu_load2_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign error        = error_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_matrix_exec_engine.sv
// Directed bench for matrix_exec_engine: memory model plus cycle-by-cycle checks.
module tb_matrix_exec_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   inst_addr;
  logic [31:0]  inst_data;
  logic         inst_valid;
  logic         mem_en, mem_we;
  logic [7:0]   mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         reg_we;
  logic [255:0] reg_wdata;
  logic [7:0]   alu_op, alu_operand2;
  logic [255:0] alu_mat_in;
  logic         alu_load1, alu_load2;
  logic [255:0] alu_result;
  logic         alu_done;
  logic         busy, halted, error;
  logic [1:0]   err_code;

  logic [31:0]  prog [0:127];
  logic [255:0] mem  [0:255];
  logic         ld_en;
  logic [7:0]   ld_addr;
  logic [255:0] ld_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_exec_engine dut (
    .clk(clk), .reset(reset),
    .inst_addr(inst_addr), .inst_data(inst_data), .inst_valid(inst_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_wdata(reg_wdata),
    .alu_op(alu_op), .alu_operand2(alu_operand2), .alu_mat_in(alu_mat_in),
    .alu_load1(alu_load1), .alu_load2(alu_load2),
    .alu_result(alu_result), .alu_done(alu_done),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code)
  );

  assign inst_data = prog[inst_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ldm(input logic [7:0] a, input logic [255:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; inst_valid = 1'b0; alu_done = 1'b0; alu_result = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) prog[i] = 32'hFF000000;

    // ADD: mem[2] = mem[0] + mem[1]
    ldm(0, 256'h11); ldm(1, 256'h22); ldm(2, 256'h0);
    prog[0] = 32'h01020001; prog[1] = 32'hFF000000;
    alu_result = 256'h33; alu_done = 1'b1; inst_valid = 1'b1;
    reset = 1'b1;
    tick(2);
    chk("rst_ctrl", {busy, halted, error, err_code, mem_en, mem_we, reg_we, alu_load1, alu_load2}, 0);
    chk("rst_pc", inst_addr, 0);
    chk("rst_alu", {alu_op, alu_operand2, alu_mat_in[15:0], mem_addr}, 0);
    reset = 1'b0;
    tick(); chk("add_dec_op", {busy, alu_op}, {1'b1, 8'h01});
    tick(); chk("add_src1", {mem_en, mem_we, mem_addr}, {2'b10, 8'd0});
    tick(); chk("add_load1", {alu_load1, mem_en, mem_addr}, {2'b11, 8'd1});
            chk("add_load1_data", alu_mat_in, 256'h11);
    tick(); chk("add_load2", {alu_load1, alu_load2}, 2'b01);
            chk("add_load2_data", alu_mat_in, 256'h22);
    tick(); chk("add_exec", {alu_load2, mem_en}, 2'b00);
    tick(); chk("add_write", {mem_en, mem_we, reg_we, mem_addr}, {3'b110, 8'd2});
            chk("add_wdata", mem_wdata, 256'h33);
    tick(); chk("add_pc", {inst_addr, mem_we}, {7'd1, 1'b0});
            chk("add_mem2", mem[2], 256'h33);
    tick(2); chk("add_halt", {halted, busy, error, inst_addr}, {3'b100, 7'd1});

    // SCALE: scalar 0x2A, dst 7 also writes the result register
    reset = 1'b1;
    ldm(4, 256'h5); ldm(7, 256'h0);
    prog[0] = 32'h0307042A; prog[1] = 32'hFF000000;
    alu_result = 256'hA5A5;
    do_reset();
    tick(); chk("scl_dec", {alu_op, alu_operand2}, 16'h032A);
    tick(); chk("scl_src1", mem_addr, 8'd4);
    tick(); chk("scl_load1", {alu_load1, mem_en}, 2'b10);
            chk("scl_load1_data", alu_mat_in, 256'h5);
    tick(); chk("scl_no_load2", {alu_load1, alu_load2}, 2'b00);
    tick(); chk("scl_write", {mem_we, reg_we, mem_addr}, {2'b11, 8'd7});
            chk("scl_regdata", reg_wdata, 256'hA5A5);
    tick(); chk("scl_pc", {inst_addr, reg_we}, {7'd1, 1'b0});
            chk("scl_mem7", mem[7], 256'hA5A5);

    // NOP, TRANS, STOP, then halt must stay static
    reset = 1'b1;
    ldm(3, 256'h77);
    prog[0] = 32'h00000000; prog[1] = 32'h040403FF; prog[2] = 32'hFF000000;
    alu_result = 256'h99;
    do_reset();
    tick(2); chk("nop_pc", inst_addr, 7'd1);
    tick(); chk("trn_dec", {alu_op, alu_operand2}, 16'h04FF);
    tick(); chk("trn_src1", {mem_en, mem_addr}, {1'b1, 8'd3});
    tick(); chk("trn_load1", alu_mat_in, 256'h77);
    tick(2); chk("trn_write", {mem_we, reg_we, mem_addr}, {2'b10, 8'd4});
    tick(); chk("trn_pc", inst_addr, 7'd2);
            chk("trn_mem4", mem[4], 256'h99);
    tick(2); chk("stop_halt", {halted, busy, error, inst_addr}, {3'b100, 7'd2});
    for (int i = 0; i < 20; i++) begin
      inst_valid = i[0];
      tick();
      chk("halt_static",
          {inst_addr, halted, busy, error, err_code, mem_en, mem_we, reg_we, alu_load1, alu_load2, alu_op, mem_addr},
          {7'd2, 3'b100, 2'b00, 5'b00000, 8'hFF, 8'd4});
    end
    inst_valid = 1'b1;

    // Illegal opcode
    reset = 1'b1; prog[0] = 32'h09000000; do_reset();
    tick(); chk("ill_dec_mem", mem_en, 1'b0);
    tick(); chk("ill_err", {error, err_code, busy, halted, mem_en}, {1'b1, 2'b01, 3'b000});

    // Binary op with src2 = NUM_CELLS
    reset = 1'b1; prog[0] = 32'h01000108; do_reset();
    tick(2); chk("src2_err", {error, err_code, mem_en, busy}, {1'b1, 2'b11, 2'b00});

    // Unary op with dst = NUM_CELLS
    reset = 1'b1; prog[0] = 32'h03080000; do_reset();
    tick(2); chk("dst_err", {error, err_code, mem_en}, {1'b1, 2'b11, 1'b0});

    // ALU never answers
    reset = 1'b1; prog[0] = 32'h040403FF; alu_done = 1'b0; do_reset();
    tick(4); chk("wd_exec", {busy, error}, 2'b10);
`ifdef EXEC_WATCHDOG_EN
    tick(63); chk("wd_before", error, 1'b0);
    tick();   chk("wd_err", {error, err_code, busy}, {1'b1, 2'b10, 1'b0});
`else
    tick(100); chk("wd_none", {error, busy, mem_en, mem_we}, 4'b0100);
`endif

    // Reset during EXEC, then instruction arrives 3 cycles late
    reset = 1'b1; do_reset();
    tick(6); chk("rx_exec", {busy, error}, 2'b10);
    inst_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rx_zero", {inst_addr, busy, halted, error, err_code, mem_en, mem_we, reg_we, alu_load1, alu_load2, alu_op, alu_operand2}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rx_fetch_hold", {busy, inst_addr, alu_op, mem_en}, {1'b1, 7'd0, 8'h00, 1'b0});
    end
    inst_valid = 1'b1;
    tick(); chk("rx_decode", alu_op, 8'h04);

    // Reset arriving in WRITE drops the write
    reset = 1'b1;
    ldm(0, 256'h11); ldm(1, 256'h22); ldm(2, 256'h5A);
    prog[0] = 32'h01020001; alu_result = 256'h33; alu_done = 1'b1;
    do_reset();
    tick(6); chk("wdrop_pre", mem_we, 1'b1);
    reset = 1'b1;
    #1; chk("wdrop_strobes", {mem_we, reg_we}, 2'b00);
    tick();
    reset = 1'b0;
    chk("wdrop_mem2", mem[2], 256'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
